poly_mult_sequencer: RTL and testbench
======================================

POLY_MULT_SEQUENCER -- requirements
Module: poly_mult_sequencer

Interface
REQ-001 SHALL have parameter N_COEF, default 4: coefficients per operand polynomial; legal 2..16.
REQ-002 SHALL have parameter PIPE, default 2: multiplier latency in cycles from operand address issue to product valid; legal 1..4.
REQ-003 SHALL have localparam AW = clog2(N_COEF) for the operand address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request one full product; sampled only in IDLE.
REQ-007 SHALL have port a_addr  output  AW  coefficient index i into operand A store.
REQ-008 SHALL have port b_addr  output  AW  coefficient index j into operand B store.
REQ-009 SHALL have port mul_en  output  1  operand pair on a_addr/b_addr is valid this cycle.
REQ-010 SHALL have port acc_en  output  1  accumulate the product arriving this cycle.
REQ-011 SHALL have port acc_clr  output  1  the arriving product replaces, not adds to, the accumulator (first term of a coefficient).
REQ-012 SHALL have port res_we  output  1  write the accumulator result to the result store.
REQ-013 SHALL have port res_addr  output  AW+1  result coefficient index k, 0..2*N_COEF-2.
REQ-014 SHALL have port busy  output  1  operation in progress.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-017 SHALL go IDLE->ISSUE on the edge where start=1 in IDLE (edge E0); start=0 keeps IDLE.
REQ-018 SHALL issue, in ISSUE, exactly one term per cycle for N_COEF^2 cycles (cycles E0+1..E0+N_COEF^2), with mul_en=1 throughout.
REQ-019 SHALL order terms by k ascending 0..2N_COEF-2, and within each k by i ascending from max(0,k-N_COEF+1) to min(k,N_COEF-1), with j=k-i.
REQ-020 SHALL mark the first term of each k as first and the last term as last (k<N_COEF: k+1 terms; otherwise 2N_COEF-1-k terms).
REQ-021 SHALL carry valid, first, last and k through a PIPE-stage delay line; acc_en, acc_clr, res_we and res_addr equal the stage-PIPE outputs of valid, valid&first, valid&last and k respectively.
REQ-022 SHALL enter DRAIN after the last issue cycle, remain PIPE cycles with mul_en=0, then enter DONE.
REQ-023 SHALL assert done for exactly one cycle in DONE (cycle E0+N_COEF^2+PIPE+1), then return to IDLE.
REQ-024 SHALL drive busy=1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-025 SHALL ignore start while busy=1; with start held high continuously, the next operation begins on the edge after the one IDLE cycle following done.
REQ-026 SHALL drive a_addr, b_addr = 0 and res_addr = 0 whenever the corresponding enable is 0.
REQ-027 SHALL use terminal-value compares on the k and i counters, with no modulo wrap past 2N_COEF-2 or N_COEF-1.

Reset
REQ-028 SHALL, on reset=1 at any time including mid-ISSUE or mid-DRAIN, immediately force IDLE, clear the delay line and counters, and drive all outputs to 0.
REQ-029 SHALL not produce a res_we or done for an operation aborted by reset after reset deasserts.

Verification
REQ-030 SHALL cover: N_COEF=4, PIPE=2, start pulse at E0 -> mul_en high on cycles 1..16, addresses (0,0),(0,1),(1,0),(0,2),(1,1),(2,0),...,(3,3); res_we on 7 cycles with res_addr 0..6; done at cycle 19; busy on cycles 1..19.
REQ-031 SHALL cover: same configuration -> acc_clr coincides with the first acc_en of each k; the first res_we (k=0) occurs at cycle 3, together with acc_clr.
REQ-032 SHALL cover: start pulsed again at cycles 5 and 19 -> no effect; exactly one done.
REQ-033 SHALL cover: start held high -> done at 19, IDLE at 20, second operation issues from cycle 21, second done at 39.
REQ-034 SHALL cover: reset asserted asynchronously at cycle 10 -> all outputs 0 before the next edge; no res_we or done afterwards; a later start runs a full clean sequence.
REQ-035 SHALL cover: N_COEF=2, PIPE=1 -> 4 issue cycles, res_addr 0,1,2 writes, done at cycle 6.

Source files
------------

// File: rtl/poly_mult_sequencer.sv
// Schoolbook polynomial-multiply address sequencer: walks every (i, j) term grouped by
// result coefficient k = i + j, and delays the accumulate/write controls to match the multiplier.
module poly_mult_sequencer #(
    parameter int N_COEF = 4,
    parameter int PIPE = 2,
    localparam int AW = $clog2(N_COEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          mul_en,
    output logic          acc_en,
    output logic          acc_clr,
    output logic          res_we,
    output logic [AW:0]   res_addr,
    output logic          busy,
    output logic          done
);

    localparam int KW = PIPE * (AW + 1);

    localparam logic [AW:0]   K_N      = (AW + 1)'(N_COEF);
    localparam logic [AW:0]   K_N_M1   = (AW + 1)'(N_COEF - 1);
    localparam logic [AW:0]   K_LAST   = (AW + 1)'(2 * N_COEF - 2);
    localparam logic [AW:0]   K_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] I_MAX    = AW'(N_COEF - 1);
    localparam logic [AW-1:0] I_ONE    = AW'(1);
    localparam logic [2:0]    D_LAST   = 3'(PIPE - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [AW:0]     k, k_nx;
    logic [AW-1:0]   i, i_nx;
    logic [2:0]      drain_cnt, drain_nx;
    logic            issue, term_first, term_last;

    logic [PIPE:1]   v_pipe, f_pipe, l_pipe;
    logic [KW-1:0]   k_pipe;

    // Lowest and highest i contributing to coefficient k.
    function automatic logic [AW-1:0] i_lo(input logic [AW:0] kk);
        if (kk >= K_N) return AW'(kk - K_N_M1);
        return '0;
    endfunction

    function automatic logic [AW-1:0] i_hi(input logic [AW:0] kk);
        if (kk < K_N) return AW'(kk);
        return I_MAX;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_nx   = state;
        k_nx       = k;
        i_nx       = i;
        drain_nx   = drain_cnt;
        issue      = (state == ISSUE);
        term_first = (i == i_lo(k));
        term_last  = (i == i_hi(k));

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                    k_nx     = '0;
                    i_nx     = '0;
                end
            end
            ISSUE: begin
                if (term_last) begin
                    if (k == K_LAST) begin
                        state_nx = DRAIN;
                        k_nx     = '0;
                        i_nx     = '0;
                        drain_nx = '0;
                    end else begin
                        k_nx = k + K_ONE;
                        i_nx = i_lo(k + K_ONE);
                    end
                end else begin
                    i_nx = i + I_ONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == D_LAST) state_nx = DONE;
                else drain_nx = drain_cnt + 3'd1;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            k         <= '0;
            i         <= '0;
            drain_cnt <= '0;
        end else begin
            // NOTE: registered state uses non-blocking assignment so all flops update from pre-edge values.
            state     <= state_nx;
            k         <= k_nx;
            i         <= i_nx;
            drain_cnt <= drain_nx;
        end
    end

    // Term tags ride alongside the multiplier; newest stage sits in the low bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the delay line is a flop chain, not a RAM, so clearing it on reset is cheap and kills aborted writes.
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
            k_pipe <= '0;
        end else begin
            v_pipe <= PIPE'({v_pipe, issue});
            f_pipe <= PIPE'({f_pipe, issue & term_first});
            l_pipe <= PIPE'({l_pipe, issue & term_last});
            k_pipe <= KW'({k_pipe, k});
        end
    end

    always_comb begin
        mul_en   = issue;
        a_addr   = issue ? i : '0;
        b_addr   = issue ? AW'(k - {1'b0, i}) : '0;
        acc_en   = v_pipe[PIPE];
        acc_clr  = f_pipe[PIPE];
        res_we   = l_pipe[PIPE];
        res_addr = l_pipe[PIPE] ? k_pipe[KW-1 -: AW+1] : '0;
        busy     = (state != IDLE);
        done     = (state == DONE);
    end

endmodule

// File: tb/tb_poly_mult_sequencer.sv
// Bench for poly_mult_sequencer: two instances (N=4/PIPE=2 and N=2/PIPE=1) checked against
// a term-order scoreboard filled at start time and drained as the DUT issues and writes.
module tb_poly_mult_sequencer;

    localparam int N4 = 4;
    localparam int P4 = 2;
    localparam int N2 = 2;
    localparam int P2 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start4 = 1'b0;
    logic       start2 = 1'b0;

    logic [1:0] a_addr4, b_addr4;
    logic [2:0] res_addr4;
    logic       mul_en4, acc_en4, acc_clr4, res_we4, busy4, done4;
    logic [0:0] a_addr2, b_addr2;
    logic [1:0] res_addr2;
    logic       mul_en2, acc_en2, acc_clr2, res_we2, busy2, done2;

    always #5 clk = ~clk;

    poly_mult_sequencer #(.N_COEF(N4), .PIPE(P4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .a_addr(a_addr4), .b_addr(b_addr4), .mul_en(mul_en4),
        .acc_en(acc_en4), .acc_clr(acc_clr4), .res_we(res_we4),
        .res_addr(res_addr4), .busy(busy4), .done(done4)
    );

    poly_mult_sequencer #(.N_COEF(N2), .PIPE(P2)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .a_addr(a_addr2), .b_addr(b_addr2), .mul_en(mul_en2),
        .acc_en(acc_en2), .acc_clr(acc_clr2), .res_we(res_we2),
        .res_addr(res_addr2), .busy(busy2), .done(done2)
    );

    typedef struct {int cyc; int a; int b;} issue_t;
    typedef struct {int cyc; bit first; bit last; int k;} prod_t;
    typedef struct {int lo; int hi;} op_t;

    issue_t issue_q [2][$];
    prod_t  prod_q  [2][$];
    op_t    op_q    [2][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    int issue_cnt [2];
    int we_cnt [2];
    int done_cnt [2];
    int done_cyc [2];
    int first_we_cyc [2];
    bit first_we_clr [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Expected term order, derived from the i + j = k grouping.
    task automatic push_op(input int d, input int e0);
        int n, p, t, lo, hi;
        issue_t it;
        prod_t pt;
        op_t ot;
        n = (d == 0) ? N4 : N2;
        p = (d == 0) ? P4 : P2;
        t = 0;
        for (int k = 0; k <= 2 * n - 2; k++) begin
            lo = (k >= n) ? k - n + 1 : 0;
            hi = (k < n) ? k : n - 1;
            for (int i = lo; i <= hi; i++) begin
                it.cyc = e0 + 1 + t; it.a = i; it.b = k - i;
                issue_q[d].push_back(it);
                pt.cyc = e0 + 1 + t + p; pt.first = (i == lo); pt.last = (i == hi); pt.k = k;
                prod_q[d].push_back(pt);
                t++;
            end
        end
        ot.lo = e0 + 1;
        ot.hi = e0 + n * n + p + 1;
        op_q[d].push_back(ot);
    endtask

    task automatic clear_stats(input int d);
        issue_cnt[d] = 0;
        we_cnt[d] = 0;
        done_cnt[d] = 0;
        done_cyc[d] = -1;
        first_we_cyc[d] = -1;
        first_we_clr[d] = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        int o_mul [2], o_a [2], o_b [2], o_acc [2], o_clr [2], o_we [2], o_ra [2], o_busy [2], o_done [2];
        issue_t ie;
        prod_t pe;
        bit exp_busy, exp_done;
        if (mon_on && !reset) begin
            o_mul[0] = int'(mul_en4); o_a[0] = int'(a_addr4); o_b[0] = int'(b_addr4);
            o_acc[0] = int'(acc_en4); o_clr[0] = int'(acc_clr4); o_we[0] = int'(res_we4);
            o_ra[0] = int'(res_addr4); o_busy[0] = int'(busy4); o_done[0] = int'(done4);
            o_mul[1] = int'(mul_en2); o_a[1] = int'(a_addr2); o_b[1] = int'(b_addr2);
            o_acc[1] = int'(acc_en2); o_clr[1] = int'(acc_clr2); o_we[1] = int'(res_we2);
            o_ra[1] = int'(res_addr2); o_busy[1] = int'(busy2); o_done[1] = int'(done2);
            for (int d = 0; d < 2; d++) begin
                if (o_mul[d] != 0) begin
                    issue_cnt[d]++;
                    checks++;
                    if (issue_q[d].size() == 0 || issue_q[d][0].cyc != cyc) begin
                        errors++;
                        $display("FAIL unexpected_mul_en dut%0d cyc %0d: got mul_en 1, expected 0", d, cyc);
                    end else begin
                        ie = issue_q[d].pop_front();
                        checks++;
                        if (o_a[d] != ie.a || o_b[d] != ie.b) begin
                            errors++;
                            $display("FAIL operand_addr dut%0d cyc %0d: got (%0d,%0d), expected (%0d,%0d)",
                                     d, cyc, o_a[d], o_b[d], ie.a, ie.b);
                        end
                    end
                end else begin
                    checks++;
                    if (o_a[d] != 0 || o_b[d] != 0) begin
                        errors++;
                        $display("FAIL idle_addr dut%0d cyc %0d: got (%0d,%0d), expected (0,0)", d, cyc, o_a[d], o_b[d]);
                    end
                    if (issue_q[d].size() > 0 && issue_q[d][0].cyc <= cyc) begin
                        errors++;
                        $display("FAIL missing_issue dut%0d cyc %0d: got mul_en 0, expected 1", d, cyc);
                        void'(issue_q[d].pop_front());
                    end
                end

                if (o_acc[d] != 0) begin
                    checks++;
                    if (prod_q[d].size() == 0 || prod_q[d][0].cyc != cyc) begin
                        errors++;
                        $display("FAIL unexpected_acc_en dut%0d cyc %0d: got acc_en 1, expected 0", d, cyc);
                    end else begin
                        pe = prod_q[d].pop_front();
                        checks++;
                        if (o_clr[d] != int'(pe.first) || o_we[d] != int'(pe.last) ||
                            o_ra[d] != (pe.last ? pe.k : 0)) begin
                            errors++;
                            $display("FAIL acc_ctrl dut%0d cyc %0d: got clr %0d we %0d addr %0d, expected clr %0d we %0d addr %0d",
                                     d, cyc, o_clr[d], o_we[d], o_ra[d], pe.first, pe.last, pe.last ? pe.k : 0);
                        end
                    end
                end else begin
                    checks++;
                    if (o_clr[d] != 0 || o_we[d] != 0 || o_ra[d] != 0) begin
                        errors++;
                        $display("FAIL idle_acc dut%0d cyc %0d: got clr %0d we %0d addr %0d, expected all 0",
                                 d, cyc, o_clr[d], o_we[d], o_ra[d]);
                    end
                    if (prod_q[d].size() > 0 && prod_q[d][0].cyc <= cyc) begin
                        errors++;
                        $display("FAIL missing_acc dut%0d cyc %0d: got acc_en 0, expected 1", d, cyc);
                        void'(prod_q[d].pop_front());
                    end
                end

                if (o_we[d] != 0) begin
                    we_cnt[d]++;
                    if (we_cnt[d] == 1) begin
                        first_we_cyc[d] = cyc;
                        first_we_clr[d] = (o_clr[d] != 0);
                    end
                end

                exp_busy = 1'b0;
                exp_done = 1'b0;
                if (op_q[d].size() > 0 && cyc >= op_q[d][0].lo) begin
                    exp_busy = 1'b1;
                    exp_done = (cyc == op_q[d][0].hi);
                end
                checks++;
                if (o_busy[d] != int'(exp_busy)) begin
                    errors++;
                    $display("FAIL busy dut%0d cyc %0d: got %0d, expected %0d", d, cyc, o_busy[d], exp_busy);
                end
                checks++;
                if (o_done[d] != int'(exp_done)) begin
                    errors++;
                    $display("FAIL done dut%0d cyc %0d: got %0d, expected %0d", d, cyc, o_done[d], exp_done);
                end
                if (o_done[d] != 0) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                end
                if (op_q[d].size() > 0 && cyc >= op_q[d][0].hi) op_q[d].delete(0);
            end
        end
    end

    task automatic check_drained(input int d, input string name);
        checks++;
        if (issue_q[d].size() + prod_q[d].size() + op_q[d].size() != 0) begin
            errors++;
            $display("FAIL %s_leftover dut%0d: got %0d pending entries, expected 0", name, d,
                     issue_q[d].size() + prod_q[d].size() + op_q[d].size());
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mul_en4, acc_en4, acc_clr4, res_we4, busy4, done4, a_addr4, b_addr4, res_addr4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs4: got nonzero outputs, expected all 0");
        end
        checks++;
        if ({mul_en2, acc_en2, acc_clr2, res_we2, busy2, done2, a_addr2, b_addr2, res_addr2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs2: got nonzero outputs, expected all 0");
        end
        @(posedge clk);
        #2 reset = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_op;
        int e0;
        clear_stats(0);
        @(negedge clk);
        start4 = 1'b1;
        e0 = cyc;
        push_op(0, e0);
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 24);
        checks++;
        if (issue_cnt[0] != 16) begin errors++; $display("FAIL single_issue_cnt: got %0d, expected 16", issue_cnt[0]); end
        checks++;
        if (we_cnt[0] != 7) begin errors++; $display("FAIL single_we_cnt: got %0d, expected 7", we_cnt[0]); end
        checks++;
        if (done_cnt[0] != 1 || done_cyc[0] - e0 != 19) begin
            errors++;
            $display("FAIL single_done: got %0d pulses at cycle %0d, expected 1 at 19", done_cnt[0], done_cyc[0] - e0);
        end
        checks++;
        if (first_we_cyc[0] - e0 != 3 || !first_we_clr[0]) begin
            errors++;
            $display("FAIL first_write: got cycle %0d clr %0d, expected cycle 3 clr 1", first_we_cyc[0] - e0, first_we_clr[0]);
        end
        check_drained(0, "single");
    endtask

    task automatic test_start_ignored;
        int e0;
        clear_stats(0);
        @(negedge clk);
        start4 = 1'b1;
        e0 = cyc;
        push_op(0, e0);
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 5);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 19);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 26);
        checks++;
        if (done_cnt[0] != 1) begin errors++; $display("FAIL ignored_done_cnt: got %0d, expected 1", done_cnt[0]); end
        checks++;
        if (we_cnt[0] != 7) begin errors++; $display("FAIL ignored_we_cnt: got %0d, expected 7", we_cnt[0]); end
        check_drained(0, "ignored");
    endtask

    task automatic test_back_to_back;
        int e0;
        clear_stats(0);
        @(negedge clk);
        start4 = 1'b1;
        e0 = cyc;
        push_op(0, e0);
        push_op(0, e0 + 20);
        wait_cyc(e0 + 20);
        checks++;
        if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %0d at cycle 20, expected 0", busy4); end
        wait_cyc(e0 + 21);
        checks++;
        if (mul_en4 !== 1'b1) begin errors++; $display("FAIL b2b_second_issue: got mul_en %0d at cycle 21, expected 1", mul_en4); end
        start4 = 1'b0;
        wait_cyc(e0 + 44);
        checks++;
        if (done_cnt[0] != 2 || done_cyc[0] - e0 != 39) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, last at %0d, expected 2, last at 39", done_cnt[0], done_cyc[0] - e0);
        end
        checks++;
        if (we_cnt[0] != 14) begin errors++; $display("FAIL b2b_we_cnt: got %0d, expected 14", we_cnt[0]); end
        check_drained(0, "b2b");
    endtask

    task automatic test_reset_abort;
        int e0;
        clear_stats(0);
        @(negedge clk);
        start4 = 1'b1;
        e0 = cyc;
        push_op(0, e0);
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 10);
        checks++;
        if (mul_en4 !== 1'b1) begin errors++; $display("FAIL abort_pre: got mul_en %0d at cycle 10, expected 1", mul_en4); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({mul_en4, acc_en4, acc_clr4, res_we4, busy4, done4, a_addr4, b_addr4, res_addr4} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got nonzero outputs before next edge, expected all 0");
        end
        issue_q[0].delete();
        prod_q[0].delete();
        op_q[0].delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        clear_stats(0);
        wait_cyc(cyc + 25);
        checks++;
        if (we_cnt[0] != 0 || done_cnt[0] != 0) begin
            errors++;
            $display("FAIL abort_residue: got %0d writes %0d dones, expected 0 0", we_cnt[0], done_cnt[0]);
        end
        clear_stats(0);
        @(negedge clk);
        start4 = 1'b1;
        e0 = cyc;
        push_op(0, e0);
        @(negedge clk);
        start4 = 1'b0;
        wait_cyc(e0 + 24);
        checks++;
        if (we_cnt[0] != 7 || done_cnt[0] != 1 || done_cyc[0] - e0 != 19) begin
            errors++;
            $display("FAIL abort_rerun: got %0d writes, %0d dones at %0d, expected 7, 1 at 19",
                     we_cnt[0], done_cnt[0], done_cyc[0] - e0);
        end
        check_drained(0, "abort");
    endtask

    task automatic test_small;
        int e0;
        clear_stats(1);
        @(negedge clk);
        start2 = 1'b1;
        e0 = cyc;
        push_op(1, e0);
        @(negedge clk);
        start2 = 1'b0;
        wait_cyc(e0 + 10);
        checks++;
        if (issue_cnt[1] != 4) begin errors++; $display("FAIL small_issue_cnt: got %0d, expected 4", issue_cnt[1]); end
        checks++;
        if (we_cnt[1] != 3) begin errors++; $display("FAIL small_we_cnt: got %0d, expected 3", we_cnt[1]); end
        checks++;
        if (done_cnt[1] != 1 || done_cyc[1] - e0 != 6) begin
            errors++;
            $display("FAIL small_done: got %0d pulses at cycle %0d, expected 1 at 6", done_cnt[1], done_cyc[1] - e0);
        end
        check_drained(1, "small");
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_start_ignored;
        test_back_to_back;
        test_reset_abort;
        test_small;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
